rpr0521rs_i2c_responder: RTL

I2C target that emulates the RPR0521RS proximity/ALS sensor at the device end of the bus, the counterpart to our sensor driver.
- Lets the driver's I2C path be exercised against real bus traffic, in simulation or on a second pin pair, without the physical sensor.
- Proximity and ALS values come from fabric inputs; control registers written by the initiator are exposed as outputs.

---
 rtl/rpr0521rs_pkg.sv | 37 +++
 rtl/i2c_bus_monitor.sv | 44 ++++
 rtl/rpr0521rs_i2c_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rpr0521rs_pkg.sv
// rtl/rpr0521rs_pkg.sv - RPR0521RS register map, reset defaults and responder FSM encoding
package rpr0521rs_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h38;

  localparam logic [7:0] REG_SYSCTRL     = 8'h40;
  localparam logic [7:0] REG_MODE_CTRL   = 8'h41;
  localparam logic [7:0] REG_ALS_PS_CTRL = 8'h42;
  localparam logic [7:0] REG_PS_CTRL     = 8'h43;
  localparam logic [7:0] REG_PS_LSB      = 8'h44;
  localparam logic [7:0] REG_PS_MSB      = 8'h45;
  localparam logic [7:0] REG_ALS0_LSB    = 8'h46;
  localparam logic [7:0] REG_ALS0_MSB    = 8'h47;
  localparam logic [7:0] REG_ALS1_LSB    = 8'h48;
  localparam logic [7:0] REG_ALS1_MSB    = 8'h49;
  localparam logic [7:0] REG_MANUF       = 8'h92;

  localparam logic [7:0] MODE_CTRL_RST   = 8'h00;
  localparam logic [7:0] ALS_PS_CTRL_RST = 8'h02;
  localparam logic [7:0] PS_CTRL_RST     = 8'h01;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_REG       = 4'd3;
  localparam logic [3:0] ST_REG_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RD_MACK   = 4'd8;
  localparam logic [3:0] ST_IGNORE    = 4'd9;

  function automatic logic is_ctrl_reg(input logic [7:0] addr);
    return (addr == REG_MODE_CTRL) || (addr == REG_ALS_PS_CTRL) || (addr == REG_PS_CTRL);
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - SCL/SDA synchronizers with START/STOP and SCL edge pulses
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic start,
  output logic stop,
  output logic scl_rise,
  output logic scl_fall
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl;
  logic                   scl_d;
  logic                   sda_d;

  // Idle-bus reset values so releasing reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl      = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign start    = scl & scl_d & sda_d & ~sda;
  assign stop     = scl & scl_d & ~sda_d & sda;
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;

endmodule

// File: rtl/rpr0521rs_i2c_responder.sv
// rtl/rpr0521rs_i2c_responder.sv - I2C target emulating the RPR0521RS sensor register interface
module rpr0521rs_i2c_responder
  import rpr0521rs_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter logic [7:0] PART_ID     = 8'h0A,
  parameter logic [7:0] MANUF_ID    = 8'hE0,
  parameter int         SYNC_STAGES = 2,
  parameter int         HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] prox_in,
  input  logic [15:0] als0_in,
  input  logic [15:0] als1_in,
  output logic [7:0]  mode_ctrl,
  output logic [7:0]  als_ps_ctrl,
  output logic [7:0]  ps_ctrl,
  output logic        wr_strobe,
  output logic [7:0]  wr_addr,
  output logic        bus_active
);

  logic        sda;
  logic        start;
  logic        stop;
  logic        scl_rise;
  logic        scl_fall;

  logic [3:0]  state;
  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;
  logic [7:0]  ptr;
  logic        rd_req;
  logic [47:0] snap;
  logic [7:0]  hold_cnt;
  logic        oe_pend;
  logic [7:0]  rd_data;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda),
    .start    (start),
    .stop     (stop),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall)
  );

  assign rx_byte = {shreg, sda};

  always_comb begin
    rd_data = 8'h00;
    case (ptr)
      REG_SYSCTRL:     rd_data = PART_ID;
      REG_MODE_CTRL:   rd_data = mode_ctrl;
      REG_ALS_PS_CTRL: rd_data = als_ps_ctrl;
      REG_PS_CTRL:     rd_data = ps_ctrl;
      REG_PS_LSB:      rd_data = snap[39:32];
      REG_PS_MSB:      rd_data = snap[47:40];
      REG_ALS0_LSB:    rd_data = snap[23:16];
      REG_ALS0_MSB:    rd_data = snap[31:24];
      REG_ALS1_LSB:    rd_data = snap[7:0];
      REG_ALS1_MSB:    rd_data = snap[15:8];
      REG_MANUF:       rd_data = MANUF_ID;
      default:         rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    wr_strobe <= 1'b0;
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      shreg       <= 7'd0;
      tx_byte     <= 8'h00;
      ptr         <= 8'h00;
      rd_req      <= 1'b0;
      snap        <= 48'd0;
      hold_cnt    <= 8'd0;
      oe_pend     <= 1'b0;
      sda_oe      <= 1'b0;
      mode_ctrl   <= MODE_CTRL_RST;
      als_ps_ctrl <= ALS_PS_CTRL_RST;
      ps_ctrl     <= PS_CTRL_RST;
      wr_addr     <= 8'h00;
      bus_active  <= 1'b0;
    end else if (stop) begin
      state      <= ST_IDLE;
      sda_oe     <= 1'b0;
      hold_cnt   <= 8'd0;
      bus_active <= 1'b0;
    end else if (start) begin
      state    <= ST_ADDR;
      bit_cnt  <= 3'd0;
      sda_oe   <= 1'b0;
      hold_cnt <= 8'd0;
    end else begin
      // SDA changes are queued at SCL fall and applied after the hold delay.
      if (hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
        if (hold_cnt == 8'd1) sda_oe <= oe_pend;
      end
      if (scl_fall && state != ST_IDLE) begin
        hold_cnt <= 8'(HOLD_CYCLES);
        case (state)
          ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: oe_pend <= 1'b1;
          ST_RDATA:                              oe_pend <= ~tx_byte[3'd7 - bit_cnt];
          default:                               oe_pend <= 1'b0;
        endcase
      end
      if (scl_rise) begin
        case (state)
          ST_ADDR, ST_REG, ST_WDATA: begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state      <= ST_ADDR_ACK;
                  bus_active <= 1'b1;
                  rd_req     <= rx_byte[0];
                  if (rx_byte[0]) snap <= {prox_in, als0_in, als1_in};
                end else begin
                  state      <= ST_IGNORE;
                  bus_active <= 1'b0;
                end
              end else if (state == ST_REG) begin
                ptr   <= rx_byte;
                state <= ST_REG_ACK;
              end else begin
                if (is_ctrl_reg(ptr)) begin
                  wr_strobe <= 1'b1;
                  wr_addr   <= ptr;
                  if (ptr == REG_MODE_CTRL)   mode_ctrl   <= rx_byte;
                  if (ptr == REG_ALS_PS_CTRL) als_ps_ctrl <= rx_byte;
                  if (ptr == REG_PS_CTRL)     ps_ctrl     <= rx_byte;
                end
                state <= ST_WDATA_ACK;
              end
            end
          end
          ST_ADDR_ACK: begin
            bit_cnt <= 3'd0;
            if (rd_req) begin
              state   <= ST_RDATA;
              tx_byte <= rd_data;
            end else begin
              state <= ST_REG;
            end
          end
          ST_REG_ACK: begin
            bit_cnt <= 3'd0;
            state   <= ST_WDATA;
          end
          ST_WDATA_ACK: begin
            bit_cnt <= 3'd0;
            ptr     <= ptr + 8'd1;
            state   <= ST_WDATA;
          end
          ST_RDATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            // Pointer advances per byte sent, so a NACKed read still moves it.
            if (bit_cnt == 3'd7) begin
              state <= ST_RD_MACK;
              ptr   <= ptr + 8'd1;
            end
          end
          ST_RD_MACK: begin
            bit_cnt <= 3'd0;
            if (!sda) begin
              state   <= ST_RDATA;
              tx_byte <= rd_data;
            end else begin
              state <= ST_IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
